// File: rtl/topk_uart_tx.sv
// Serialises each query's top-k result words as one 8N1 UART packet:
// 0xA5, words little-endian, word count, XOR checksum.
module topk_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  result_valid_in,
  input  logic                  result_last_in,
  output logic                  result_ready_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_SYNC  = 3'd1;
  localparam logic [2:0] F_DATA  = 3'd2;
  localparam logic [2:0] F_WAIT  = 3'd3;
  localparam logic [2:0] F_COUNT = 3'd4;
  localparam logic [2:0] F_CSUM  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_q, last_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            csum_q, csum_d;
  logic [9:0]            sh_q, sh_d;
  logic [3:0]            bit_q, bit_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;

  logic       accept, bit_end, byte_end, load;
  logic [7:0] load_byte;

  function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  function automatic logic [7:0] word_byte(input logic [DATA_WIDTH-1:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  assign result_ready_out = rst_in && (state_q == F_IDLE || state_q == F_WAIT);
  assign accept           = result_valid_in && result_ready_out;
  assign bit_end          = active_q && (baud_q == BAUD_LAST);
  assign byte_end         = bit_end && (bit_q == 4'd9);

  assign tx_out         = sh_q[0];
  assign busy_out       = (state_q != F_IDLE);
  assign frame_done_out = done_q;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    bidx_d    = bidx_q;
    n_d       = n_q;
    csum_d    = csum_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    active_d  = active_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_byte = 8'hFF;

    case (state_q)
      F_IDLE: if (accept) begin
        word_d    = result_in;
        last_d    = result_last_in;
        n_d       = 8'd1;
        csum_d    = xor_bytes(result_in);
        load      = 1'b1;
        load_byte = 8'hA5;
        state_d   = F_SYNC;
      end
      F_SYNC: if (byte_end) begin
        load      = 1'b1;
        load_byte = word_byte(word_q, 2'd0);
        bidx_d    = 2'd0;
        state_d   = F_DATA;
      end
      F_DATA: if (byte_end) begin
        if (bidx_q != 2'd3) begin
          load      = 1'b1;
          load_byte = word_byte(word_q, bidx_q + 2'd1);
          bidx_d    = bidx_q + 2'd1;
        end else if (last_q) begin
          load      = 1'b1;
          load_byte = n_q;
          state_d   = F_COUNT;
        end else begin
          state_d   = F_WAIT;
        end
      end
      // Line idles high here until the next word arrives; no timeout.
      F_WAIT: if (accept) begin
        word_d    = result_in;
        last_d    = result_last_in;
        n_d       = n_q + 8'd1;
        csum_d    = csum_q ^ xor_bytes(result_in);
        load      = 1'b1;
        load_byte = word_byte(result_in, 2'd0);
        bidx_d    = 2'd0;
        state_d   = F_DATA;
      end
      F_COUNT: if (byte_end) begin
        load      = 1'b1;
        load_byte = csum_q ^ n_q;
        state_d   = F_CSUM;
      end
      // Hold F_CSUM through the done pulse so ready stays low that cycle.
      F_CSUM: begin
        if (byte_end) done_d = 1'b1;
        else if (!active_q) state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase

    if (load) begin
      sh_d     = {1'b1, load_byte, 1'b0};
      bit_d    = 4'd0;
      baud_d   = '0;
      active_d = 1'b1;
    end else if (byte_end) begin
      sh_d     = 10'h3FF;
      bit_d    = 4'd0;
      baud_d   = '0;
      active_d = 1'b0;
    end else if (bit_end) begin
      sh_d     = {1'b1, sh_q[9:1]};
      bit_d    = bit_q + 4'd1;
      baud_d   = '0;
    end else if (active_q) begin
      baud_d   = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= F_IDLE;
      bidx_q   <= 2'd0;
      n_q      <= 8'd0;
      csum_q   <= 8'd0;
      sh_q     <= 10'h3FF;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bidx_q   <= bidx_d;
      n_q      <= n_d;
      csum_q   <= csum_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    word_q <= word_d;
    last_q <= last_d;
  end

endmodule

// File: tb/tb_topk_uart_tx.sv
// Bench for topk_uart_tx: byte-level packet model checked every cycle,
// a UART decoder on tx_out, and directed frames with literal byte lists.
module tb_topk_uart_tx;

  localparam int DIV0 = 10;
  localparam int DIV1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [31:0] d0 = '0, d1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic        rdy0, tx0, busy0, done0;
  logic        rdy1, tx1, busy1, done1;

  topk_uart_tx #(.CLK_HZ(1000), .BAUD(100)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .result_in(d0), .result_valid_in(v0),
    .result_last_in(l0), .result_ready_out(rdy0), .tx_out(tx0),
    .busy_out(busy0), .frame_done_out(done0));

  topk_uart_tx #(.CLK_HZ(1000), .BAUD(500)) u_wrap (
    .clk_in(clk), .rst_in(rst_n), .result_in(d1), .result_valid_in(v1),
    .result_last_in(l1), .result_ready_out(rdy1), .tx_out(tx1),
    .busy_out(busy1), .frame_done_out(done1));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet model for u_dut: on each accepted word the bytes it commits are
  // appended as per-cycle line levels; ready means nothing left to send.
  bit         mq[$];
  logic [7:0] mlog[$];
  logic [7:0] m_n = 8'd0, m_csum = 8'd0;
  bit         m_inframe = 0, m_closing = 0, m_done = 0;

  task automatic push_byte(input logic [7:0] b);
    mlog.push_back(b);
    for (int k = 0; k < 10; k++) begin
      bit lv;
      lv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (DIV0) mq.push_back(lv);
    end
  endtask

  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_inframe = 0; m_closing = 0; m_done = 0; m_n = 8'd0; m_csum = 8'd0;
    end else begin
      acc = v0 && (mq.size() == 0) && !m_done;
      if (mq.size() > 0) void'(mq.pop_front());
      if (m_done) begin
        m_done = 0; m_inframe = 0;
      end else if (m_closing && mq.size() == 0) begin
        m_done = 1; m_closing = 0;
      end
      if (acc) begin
        if (!m_inframe) begin
          m_inframe = 1; m_n = 8'd0; m_csum = 8'd0;
          push_byte(8'hA5);
        end
        m_n = m_n + 8'd1;
        for (int k = 0; k < 4; k++) begin
          m_csum ^= d0[8*k +: 8];
          push_byte(d0[8*k +: 8]);
        end
        if (l0) begin
          m_csum ^= m_n;
          push_byte(m_n);
          push_byte(m_csum);
          m_closing = 1;
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    if (!rst_n) begin
      chk("rst_tx", 32'(tx0), 32'd1);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_ready", 32'(rdy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
    end else begin
      chk("tx", 32'(tx0), (mq.size() > 0) ? 32'(mq[0]) : 32'd1);
      chk("busy", 32'(busy0), 32'(m_inframe));
      chk("ready", 32'(rdy0), 32'((mq.size() == 0) && !m_done));
      chk("done", 32'(done0), 32'(m_done));
    end
  end

  int acc0 = 0, acc1 = 0, dcnt0 = 0, dcnt1 = 0;
  always @(negedge clk) begin
    if (rst_n && v0 && rdy0) acc0++;
    if (rst_n && v1 && rdy1) acc1++;
    if (done0) dcnt0++;
    if (done1) dcnt1++;
  end

  // UART receivers sampling mid-bit on both instances.
  logic [7:0] rxq0[$], rxq1[$];
  bit         rb[2];
  int         rc[2];
  logic [7:0] rs[2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic t;
      int   dv;
      t  = (i == 0) ? tx0 : tx1;
      dv = (i == 0) ? DIV0 : DIV1;
      if (!rst_n) rb[i] = 0;
      else if (!rb[i]) begin
        if (t == 1'b0) begin rb[i] = 1; rc[i] = 0; end
      end else begin
        rc[i]++;
        if ((rc[i] % dv) == dv / 2 && rc[i] / dv >= 1 && rc[i] / dv <= 8)
          rs[i][rc[i] / dv - 1] = t;
        if (rc[i] == 10 * dv - 1) begin
          rb[i] = 0;
          if (i == 0) rxq0.push_back(rs[i]); else rxq1.push_back(rs[i]);
        end
      end
    end
  end

  task automatic wait_acc(input int inst, output int t);
    int n;
    bit got;
    n = 0; got = 0;
    while (!got && n < 5000) begin
      @(negedge clk);
      got = (inst == 0) ? (rdy0 && v0 && rst_n) : (rdy1 && v1 && rst_n);
      @(posedge clk);
      n++;
    end
    #1;
    t = cyc;
    chk($sformatf("accept%0d_in_time", inst), 32'(got), 32'd1);
  endtask

  task automatic put(input int inst, input logic [31:0] w, input logic last, output int t);
    if (inst == 0) begin d0 = w; l0 = last; v0 = 1'b1; end
    else begin d1 = w; l1 = last; v1 = 1'b1; end
    wait_acc(inst, t);
    if (inst == 0) begin v0 = 1'b0; l0 = 1'b0; end
    else begin v1 = 1'b0; l1 = 1'b0; end
  endtask

  task automatic wait_done(input int inst, output int t);
    int n;
    bit got;
    n = 0; got = 0;
    while (!got && n < 30000) begin
      @(negedge clk);
      got = (inst == 0) ? done0 : done1;
      n++;
    end
    t = cyc;
    chk($sformatf("done%0d_in_time", inst), 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready0(output int t);
    int n;
    n = 0;
    while (!rdy0 && n < 5000) begin @(negedge clk); n++; end
    t = cyc;
    chk("ready0_in_time", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string nm, input logic [7:0] e[$]);
    chk({nm, "_rx_len"}, rxq0.size(), e.size());
    chk({nm, "_model_len"}, mlog.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < rxq0.size()) chk($sformatf("%s_rx%0d", nm, i), 32'(rxq0[i]), 32'(e[i]));
      if (i < mlog.size()) chk($sformatf("%s_model%0d", nm, i), 32'(mlog[i]), 32'(e[i]));
    end
    rxq0.delete();
    mlog.delete();
  endtask

  initial begin
    logic [7:0] ef[$];
    int ta, td, tr, tw, ab, dc;

    #1 rst_n = 1'b0;
    chk_on = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_ready", 32'(rdy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single-word frame, latency and total length
    dc = dcnt0;
    chk("t1_tx_idle", 32'(tx0), 32'd1);
    put(0, 32'h0000_0005, 1'b1, ta);
    chk("t1_start_latency", 32'(tx0), 32'd0);
    wait_done(0, td);
    chk("t1_done_distance", td - ta, 32'd700);
    chk("t1_done_count", dcnt0 - dc, 32'd1);
    ef = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04};
    check_frame("t1", ef);

    // Two words; ready returns only once the first word's bytes are out
    put(0, 32'h1122_3344, 1'b0, ta);
    wait_ready0(tr);
    chk("t2_ready_rise", tr - ta, 32'd500);
    put(0, 32'h0000_00AA, 1'b1, ta);
    wait_done(0, td);
    ef = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h02, 8'hEC};
    check_frame("t2", ef);

    // Backpressure: valid held high from reset release
    rst_n = 1'b0;
    d0 = 32'hDEAD_BEEF; v0 = 1'b1; l0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ab = acc0;
    rxq0.delete(); mlog.delete();
    wait_acc(0, ta);
    wait_acc(0, ta);
    l0 = 1'b1;
    wait_acc(0, ta);
    v0 = 1'b0; l0 = 1'b0;
    wait_done(0, td);
    chk("t3_accept_count", acc0 - ab, 32'd3);
    ef = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h03, 8'h21};
    check_frame("t3", ef);

    // Long idle gap in the middle of a frame
    put(0, 32'h0102_0304, 1'b0, ta);
    wait_ready0(tw);
    repeat (250) @(posedge clk);
    #1;
    chk("t4_gap_tx", 32'(tx0), 32'd1);
    chk("t4_gap_busy", 32'(busy0), 32'd1);
    chk("t4_gap_ready", 32'(rdy0), 32'd1);
    repeat (249) @(posedge clk);
    #1;
    put(0, 32'h0000_000F, 1'b1, ta);
    chk("t4_gap_length_ok", 32'(ta - tw >= 500), 32'd1);
    wait_done(0, td);
    ef = '{8'hA5, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h02, 8'h09};
    check_frame("t4", ef);

    // Reset in the middle of the first data byte
    put(0, 32'h1234_5678, 1'b1, ta);
    repeat (150) @(posedge clk);
    #1;
    dc = dcnt0;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_tx", 32'(tx0), 32'd1);
    chk("t5_abort_ready", 32'(rdy0), 32'd0);
    chk("t5_abort_busy", 32'(busy0), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (800) @(posedge clk);
    #1;
    chk("t5_no_done", dcnt0 - dc, 32'd0);
    chk("t5_idle_tx", 32'(tx0), 32'd1);
    rxq0.delete(); mlog.delete();
    put(0, 32'h0000_0007, 1'b1, ta);
    wait_done(0, td);
    ef = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h01, 8'h06};
    check_frame("t5", ef);

    // 256-word frame on the fast instance: count wraps to zero
    rxq1.delete();
    dc = dcnt1;
    ab = acc1;
    for (int i = 0; i < 256; i++) put(1, 32'h0, (i == 255), ta);
    wait_done(1, td);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_accept_count", acc1 - ab, 32'd256);
    chk("t6_done_count", dcnt1 - dc, 32'd1);
    chk("t6_rx_len", rxq1.size(), 32'd1027);
    if (rxq1.size() == 1027) begin
      chk("t6_sync", 32'(rxq1[0]), 32'hA5);
      chk("t6_data_last", 32'(rxq1[1024]), 32'h00);
      chk("t6_count", 32'(rxq1[1025]), 32'h00);
      chk("t6_csum", 32'(rxq1[1026]), 32'h00);
    end
    chk("t6_idle_ready", 32'(rdy1), 32'd1);
    chk("t6_idle_busy", 32'(busy1), 32'd0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/topk_uart_tx.md
Name: topk_uart_tx

Overview:
- Host-side return path for the search core's results.
- Accepts the top-k result words the search core emits, one word per valid/ready handshake, with `last_in` marking the final word of a query.
- Serialises each query's results as one framed packet on a UART TX line (8N1), so the host reads results directly instead of polling the debug core register by register.
- Sits between the result FIFO output and the board `uart_txd` pin.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate. Local BAUD_DIV = CLK_HZ/BAUD (integer division, truncating). BAUD_DIV >= 2 is required.
- DATA_WIDTH, 32, result word width; fixed at 32 (sent as 4 bytes).

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-low reset.
- result_in, input, 32, result word (vertex id).
- result_valid_in, input, 1, result_in is valid.
- result_last_in, input, 1, qualifies result_in as the last word of the query; sampled with valid.
- result_ready_out, output, 1, block can accept a word this cycle.
- tx_out, output, 1, UART serial output, idle high.
- busy_out, output, 1, a frame is in progress.
- frame_done_out, output, 1, one-cycle pulse after the checksum stop bit completes.

Behaviour:
- Reset (rst_in low, asynchronous): tx_out=1, busy_out=0, frame_done_out=0, result_ready_out=0; frame FSM to F_IDLE; byte count and checksum cleared.
- result_ready_out=1 only in F_IDLE or F_WAIT, and only while rst_in is high.
- Handshake: a word is accepted on a rising clock edge with valid&&ready. The word and its last flag are latched; result_in need not be held afterwards.
- Frame format: 0xA5, then each word as 4 bytes little-endian, then N[7:0], then CSUM.
  - N = number of words in the frame, modulo 256.
  - CSUM = XOR of every byte after 0xA5, including the N byte.
- Frame FSM states and transitions:
  - F_IDLE: accept a word -> F_SYNC.
  - F_SYNC: send 0xA5 -> F_DATA.
  - F_DATA: send the 4 bytes of the latched word. If its last flag is set -> F_COUNT, else -> F_WAIT.
  - F_WAIT: tx idle high; wait indefinitely, no timeout. Accept a word -> F_DATA.
  - F_COUNT: send N -> F_CSUM.
  - F_CSUM: send CSUM, then pulse frame_done_out -> F_IDLE.
- N increments on each accepted word. N and CSUM clear on entry to F_SYNC.
- Byte serialiser:
  - Sequence: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly BAUD_DIV cycles.
  - Bytes within a frame go back-to-back: the next start bit follows the previous stop bit with no idle cycles, except in F_WAIT.
- Latency: tx_out falls (start bit of 0xA5) on the cycle after the accepting edge. In F_WAIT, the start bit of byte 0 falls on the cycle after acceptance.
- busy_out=1 from the cycle after the first accept until the frame_done_out cycle inclusive; busy_out=0 in F_IDLE.
- Backpressure: while ready=0, valid may stay high with data held stable. No word is consumed or dropped. A word with last=1 in F_IDLE produces a 1-entry frame.
- Wrap: more than 255 words per frame is legal; N wraps and CSUM uses the wrapped N.
- Reset mid-frame: the frame is aborted, tx_out goes high immediately, and no frame_done_out is produced. The next frame after reset release starts with N=0 and CSUM=0.
- Accept and frame_done_out cannot coincide, since ready=0 outside F_IDLE/F_WAIT.

Test Plan:
- CLK_HZ=1000, BAUD=100 (BAUD_DIV=10); one word 0x00000005, last=1 -> bytes A5 05 00 00 00 01 04 on tx_out. Each bit is 10 cycles and each byte 100 cycles. tx_out falls 1 cycle after the accept. frame_done_out pulses once, 700 cycles after the first start bit.
- Two words 0x11223344 then 0x000000AA (last) -> A5 44 33 22 11 AA 00 00 00 02 EC. result_ready_out rises only after the 4th data byte's stop bit; there is no gap between the first five bytes.
- Backpressure: hold valid=1 with 0xDEADBEEF from reset release through a 3-word frame. Exactly 3 accepts occur, each only in F_IDLE/F_WAIT. The decoded words match the sequence presented.
- Idle gap: present the second word 500 cycles after F_WAIT entry. tx_out stays high throughout the gap, the frame completes correctly with N=2, and busy_out stays 1 across the gap.
- Reset mid-byte during F_DATA: tx_out=1 and ready=0 immediately; no frame_done_out. After release, a 1-word frame 0x00000007 yields A5 07 00 00 00 01 06.
- Wrap: 256 words of 0x00000000, last on the 256th -> N byte 0x00, CSUM 0x00, frame_done_out pulses once.
